// File: rtl/mac_accumulate.sv
// mac_accumulate: sums a group of LEN unsigned products into a wide
// accumulator. The group result is presented on a valid/ready port with a
// sticky overflow flag. The input stalls while a result waits to be consumed.
module mac_accumulate #(
  parameter int unsigned MAC_MULT_WIDTH = 16,
  parameter int unsigned MAC_ACC_WIDTH  = 32,
  parameter int unsigned MAC_CNT_WIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [MAC_MULT_WIDTH-1:0] prod,
  input  logic                      prod_valid,
  output logic                      prod_ready,
  input  logic [MAC_CNT_WIDTH-1:0]  len,
  output logic [MAC_ACC_WIDTH-1:0]  acc,
  output logic                      acc_ovf,
  output logic                      acc_valid,
  input  logic                      acc_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [MAC_ACC_WIDTH-1:0] acc_q, acc_d;
  logic                     ovf_q, ovf_d;
  logic [MAC_CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic                     accept;
  logic [MAC_CNT_WIDTH-1:0] len_eff;
  logic [MAC_ACC_WIDTH:0]   sum;

  // Handshake outputs depend only on the state register (and rst for ready).
  assign prod_ready = !rst && (state_q != HOLD);
  assign acc_valid  = (state_q == HOLD);
  assign acc        = acc_q;
  assign acc_ovf    = ovf_q;

  assign accept  = prod_valid && prod_ready;
  // A group length of zero is treated as a single-product group.
  assign len_eff = (len == '0) ? MAC_CNT_WIDTH'(1) : len;
  // Extra top bit of the sum captures the carry-out of the modulo add.
  assign sum     = {1'b0, acc_q} + {1'b0, MAC_ACC_WIDTH'(prod)};

  // Next-state and datapath update for the group sequencer.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = MAC_ACC_WIDTH'(prod);
          ovf_d   = 1'b0;
          cnt_d   = len_eff - MAC_CNT_WIDTH'(1);
          state_d = (len_eff == MAC_CNT_WIDTH'(1)) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_d = sum[MAC_ACC_WIDTH-1:0];
          ovf_d = ovf_q | sum[MAC_ACC_WIDTH];
          cnt_d = cnt_q - MAC_CNT_WIDTH'(1);
          if (cnt_q == MAC_CNT_WIDTH'(1)) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (acc_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
